s4_maxpool_buffer: RTL and testbench

- S4 subsampling stage directly downstream of the C3 register controller.
- Each input cycle delivers one 2x2 C3 window for all 16 channels. The block max-pools each window to one byte per channel.
- Pooled pixels are collected into a 5x5x16 frame in a two-bank (ping-pong) buffer.
- Completed frames stream out in raster order to C5 over a valid/ready handshake.

---
 rtl/s4_maxpool_buffer.sv | 173 +++++++++++++++++
 tb/tb_s4_maxpool_buffer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s4_maxpool_buffer.sv
// S4 subsampling: 2x2 max-pool of 16-channel C3 windows into a ping-pong 5x5x16 frame
// buffer that streams completed frames to C5 in raster order over valid/ready.
module s4_maxpool_buffer #(
    parameter bit SIGNED = 1'b0,
    parameter int POOL_W = 5,
    parameter int POOL_H = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s4_in_valid,
    input  logic [31:0]  s4_in_ch_0,
    input  logic [31:0]  s4_in_ch_1,
    input  logic [31:0]  s4_in_ch_2,
    input  logic [31:0]  s4_in_ch_3,
    input  logic [31:0]  s4_in_ch_4,
    input  logic [31:0]  s4_in_ch_5,
    input  logic [31:0]  s4_in_ch_6,
    input  logic [31:0]  s4_in_ch_7,
    input  logic [31:0]  s4_in_ch_8,
    input  logic [31:0]  s4_in_ch_9,
    input  logic [31:0]  s4_in_ch_10,
    input  logic [31:0]  s4_in_ch_11,
    input  logic [31:0]  s4_in_ch_12,
    input  logic [31:0]  s4_in_ch_13,
    input  logic [31:0]  s4_in_ch_14,
    input  logic [31:0]  s4_in_ch_15,
    output logic         s4_out_valid,
    input  logic         s4_out_ready,
    output logic [127:0] s4_out_data,
    output logic [2:0]   s4_out_row,
    output logic [2:0]   s4_out_col,
    output logic         s4_out_last,
    output logic         s4_overflow
);

    localparam int PIX    = POOL_W * POOL_H;
    localparam int ADDR_W = $clog2(2 * PIX);

    logic [31:0]       in_win [16];
    logic              pool_valid;
    logic [127:0]      pool_data;
    logic [2:0]        wr_col, wr_row, rd_col, rd_row;
    logic              wr_bank, rd_bank, discard;
    logic [1:0]        full, full_next;
    logic              wr_first, wr_end, wr_skip, wr_en, frame_done;
    logic              rd_accept, rd_end, rd_done;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [127:0]      mem [2*PIX];

    assign in_win[0]  = s4_in_ch_0;
    assign in_win[1]  = s4_in_ch_1;
    assign in_win[2]  = s4_in_ch_2;
    assign in_win[3]  = s4_in_ch_3;
    assign in_win[4]  = s4_in_ch_4;
    assign in_win[5]  = s4_in_ch_5;
    assign in_win[6]  = s4_in_ch_6;
    assign in_win[7]  = s4_in_ch_7;
    assign in_win[8]  = s4_in_ch_8;
    assign in_win[9]  = s4_in_ch_9;
    assign in_win[10] = s4_in_ch_10;
    assign in_win[11] = s4_in_ch_11;
    assign in_win[12] = s4_in_ch_12;
    assign in_win[13] = s4_in_ch_13;
    assign in_win[14] = s4_in_ch_14;
    assign in_win[15] = s4_in_ch_15;

    function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
        if (SIGNED)
            return ($signed(a) > $signed(b)) ? a : b;
        return (a > b) ? a : b;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pool_valid <= 1'b0;
            pool_data  <= '0;
        end else begin
            pool_valid <= s4_in_valid;
            if (s4_in_valid) begin
                for (int k = 0; k < 16; k++) begin
                    pool_data[8*k +: 8] <= max2(max2(in_win[k][31:24], in_win[k][23:16]),
                                                max2(in_win[k][15:8],  in_win[k][7:0]));
                end
            end
        end
    end

    // The overflow decision is taken at pixel (0,0) and then held in discard for the frame.
    always_comb begin
        wr_first   = (wr_row == 3'd0) && (wr_col == 3'd0);
        wr_end     = (wr_row == 3'(POOL_H - 1)) && (wr_col == 3'(POOL_W - 1));
        wr_skip    = wr_first ? full[wr_bank] : discard;
        wr_en      = pool_valid && !wr_skip;
        frame_done = wr_en && wr_end;
        wr_addr    = (wr_bank ? ADDR_W'(PIX) : ADDR_W'(0))
                   + ADDR_W'(wr_row) * ADDR_W'(POOL_W) + ADDR_W'(wr_col);
        rd_accept  = s4_out_valid && s4_out_ready;
        rd_end     = (rd_row == 3'(POOL_H - 1)) && (rd_col == 3'(POOL_W - 1));
        rd_done    = rd_accept && rd_end;
        rd_addr    = (rd_bank ? ADDR_W'(PIX) : ADDR_W'(0))
                   + ADDR_W'(rd_row) * ADDR_W'(POOL_W) + ADDR_W'(rd_col);
    end

    // Set and clear always target different banks, so both can land in one cycle.
    always_comb begin
        full_next = full;
        if (rd_done)
            full_next[rd_bank] = 1'b0;
        if (frame_done)
            full_next[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full        <= 2'b00;
            wr_col      <= 3'd0;
            wr_row      <= 3'd0;
            wr_bank     <= 1'b0;
            discard     <= 1'b0;
            s4_overflow <= 1'b0;
            rd_col      <= 3'd0;
            rd_row      <= 3'd0;
            rd_bank     <= 1'b0;
        end else begin
            full <= full_next;
            if (pool_valid) begin
                if (wr_first) begin
                    discard <= full[wr_bank];
                    if (full[wr_bank])
                        s4_overflow <= 1'b1;
                end
                if (wr_end) begin
                    wr_col <= 3'd0;
                    wr_row <= 3'd0;
                    if (!wr_skip)
                        wr_bank <= ~wr_bank;
                end else if (wr_col == 3'(POOL_W - 1)) begin
                    wr_col <= 3'd0;
                    wr_row <= wr_row + 3'd1;
                end else begin
                    wr_col <= wr_col + 3'd1;
                end
            end
            if (rd_accept) begin
                if (rd_end) begin
                    rd_col  <= 3'd0;
                    rd_row  <= 3'd0;
                    rd_bank <= ~rd_bank;
                end else if (rd_col == 3'(POOL_W - 1)) begin
                    rd_col <= 3'd0;
                    rd_row <= rd_row + 3'd1;
                end else begin
                    rd_col <= rd_col + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en)
            mem[wr_addr] <= pool_data;
    end

    // Data is gated with valid so every output reads zero straight after reset.
    always_comb begin
        s4_out_valid = full[rd_bank];
        s4_out_data  = s4_out_valid ? mem[rd_addr] : '0;
        s4_out_row   = rd_row;
        s4_out_col   = rd_col;
        s4_out_last  = s4_out_valid && rd_end;
    end

endmodule

// File: tb/tb_s4_maxpool_buffer.sv
// Bench for s4_maxpool_buffer: an unsigned and a signed instance share stimulus and are
// compared every cycle against a frame-queue reference model, plus directed vectors.
module tb_s4_maxpool_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, ready;
    logic [31:0]  in_win [16];
    logic         valid_u, last_u, ovf_u, valid_s, last_s, ovf_s;
    logic [127:0] data_u, data_s;
    logic [2:0]   row_u, col_u, row_s, col_s;

    s4_maxpool_buffer #(.SIGNED(1'b0), .POOL_W(5), .POOL_H(5)) dut_u (
        .clk(clk), .rst_n(rst_n), .s4_in_valid(in_valid),
        .s4_in_ch_0(in_win[0]),   .s4_in_ch_1(in_win[1]),   .s4_in_ch_2(in_win[2]),   .s4_in_ch_3(in_win[3]),
        .s4_in_ch_4(in_win[4]),   .s4_in_ch_5(in_win[5]),   .s4_in_ch_6(in_win[6]),   .s4_in_ch_7(in_win[7]),
        .s4_in_ch_8(in_win[8]),   .s4_in_ch_9(in_win[9]),   .s4_in_ch_10(in_win[10]), .s4_in_ch_11(in_win[11]),
        .s4_in_ch_12(in_win[12]), .s4_in_ch_13(in_win[13]), .s4_in_ch_14(in_win[14]), .s4_in_ch_15(in_win[15]),
        .s4_out_valid(valid_u), .s4_out_ready(ready), .s4_out_data(data_u),
        .s4_out_row(row_u), .s4_out_col(col_u), .s4_out_last(last_u), .s4_overflow(ovf_u)
    );

    s4_maxpool_buffer #(.SIGNED(1'b1), .POOL_W(5), .POOL_H(5)) dut_s (
        .clk(clk), .rst_n(rst_n), .s4_in_valid(in_valid),
        .s4_in_ch_0(in_win[0]),   .s4_in_ch_1(in_win[1]),   .s4_in_ch_2(in_win[2]),   .s4_in_ch_3(in_win[3]),
        .s4_in_ch_4(in_win[4]),   .s4_in_ch_5(in_win[5]),   .s4_in_ch_6(in_win[6]),   .s4_in_ch_7(in_win[7]),
        .s4_in_ch_8(in_win[8]),   .s4_in_ch_9(in_win[9]),   .s4_in_ch_10(in_win[10]), .s4_in_ch_11(in_win[11]),
        .s4_in_ch_12(in_win[12]), .s4_in_ch_13(in_win[13]), .s4_in_ch_14(in_win[14]), .s4_in_ch_15(in_win[15]),
        .s4_out_valid(valid_s), .s4_out_ready(ready), .s4_out_data(data_s),
        .s4_out_row(row_s), .s4_out_col(col_s), .s4_out_last(last_s), .s4_overflow(ovf_s)
    );

    typedef struct {
        logic [31:0] win;
        logic [7:0]  exp_u;
        logic [7:0]  exp_s;
    } vec_t;

    typedef struct {
        logic [127:0] u;
        logic [127:0] s;
    } pix_t;

    vec_t tbl [16];
    pix_t outq [$];
    pix_t build [$];
    pix_t pend;
    bit   pend_v, discard_m, exp_ovf;
    int   rd_pos, wcount, accepted, lasts;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference pooling: largest of the four bytes, interpreted per signedness.
    function automatic logic [7:0] ref_max(input logic [31:0] w, input bit sgn);
        int best;
        int v;
        logic [7:0] by;
        logic [7:0] res;
        best = -1000;
        res = 8'd0;
        for (int b = 0; b < 4; b++) begin
            by = w[8*b +: 8];
            v = int'(by);
            if (sgn && v > 127)
                v = v - 256;
            if (v > best) begin
                best = v;
                res = by;
            end
        end
        return res;
    endfunction

    function automatic pix_t pool_ref();
        pix_t p;
        for (int k = 0; k < 16; k++) begin
            p.u[8*k +: 8] = ref_max(in_win[k], 1'b0);
            p.s[8*k +: 8] = ref_max(in_win[k], 1'b1);
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        outq.delete();
        build.delete();
        pend_v = 1'b0;
        discard_m = 1'b0;
        exp_ovf = 1'b0;
        rd_pos = 0;
        wcount = 0;
    endtask

    // One clock edge of the reference: the pooled pixel from the previous input lands
    // in the frame being built, while the front of the output queue may be consumed.
    task automatic model_edge();
        bit acc;
        int nfr;
        acc = (outq.size() > 0) && ready;
        nfr = (outq.size() + rd_pos) / 25;
        if (pend_v) begin
            if (wcount == 0) begin
                discard_m = (nfr == 2);
                if (discard_m)
                    exp_ovf = 1'b1;
            end
            if (!discard_m)
                build.push_back(pend);
            wcount++;
            if (wcount == 25) begin
                wcount = 0;
                if (!discard_m)
                    foreach (build[i]) outq.push_back(build[i]);
                build.delete();
            end
        end
        if (acc) begin
            void'(outq.pop_front());
            accepted++;
            rd_pos = (rd_pos == 24) ? 0 : rd_pos + 1;
        end
        pend_v = in_valid;
        if (in_valid)
            pend = pool_ref();
    endtask

    task automatic check_output();
        bit ev;
        ev = (outq.size() > 0);
        chk("valid_u", 128'(valid_u), 128'(ev));
        chk("valid_s", 128'(valid_s), 128'(ev));
        if (ev) begin
            chk("data_u", data_u, outq[0].u);
            chk("data_s", data_s, outq[0].s);
            chk("row", 128'(row_u), 128'(rd_pos / 5));
            chk("col", 128'(col_u), 128'(rd_pos % 5));
            chk("last", 128'(last_u), 128'(rd_pos == 24));
        end
        chk("ovf_u", 128'(ovf_u), 128'(exp_ovf));
        chk("ovf_s", 128'(ovf_s), 128'(exp_ovf));
    endtask

    // Called at a negedge with in_win already set; returns at the following negedge.
    task automatic apply_stimulus(input bit v, input bit rdy);
        check_output();
        in_valid = v;
        ready = rdy;
        if (valid_u && last_u && rdy)
            lasts++;
        model_edge();
        @(negedge clk);
    endtask

    task automatic rand_win();
        for (int k = 0; k < 16; k++)
            in_win[k] = $urandom;
    endtask

    task automatic send_frames(input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            rand_win();
            apply_stimulus(1'b1, rdy);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        model_reset();
        chk("rst_valid", 128'(valid_u), 128'(0));
        chk("rst_data", data_u, 128'(0));
        chk("rst_row", 128'(row_u), 128'(0));
        chk("rst_col", 128'(col_u), 128'(0));
        chk("rst_last", 128'(last_u), 128'(0));
        chk("rst_ovf", 128'(ovf_u), 128'(0));
        chk("rst_valid_s", 128'(valid_s), 128'(0));
        chk("rst_data_s", data_s, 128'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        tbl[0]  = '{32'h10203040, 8'h40, 8'h40};
        tbl[1]  = '{32'h80FF7F01, 8'hFF, 8'h7F};
        tbl[2]  = '{32'h40302010, 8'h40, 8'h40};
        tbl[3]  = '{32'h00000000, 8'h00, 8'h00};
        tbl[4]  = '{32'hFFFFFFFF, 8'hFF, 8'hFF};
        tbl[5]  = '{32'h80808080, 8'h80, 8'h80};
        tbl[6]  = '{32'h01FE0203, 8'hFE, 8'h03};
        tbl[7]  = '{32'h7F800001, 8'h80, 8'h7F};
        tbl[8]  = '{32'h0AFF0B0C, 8'hFF, 8'h0C};
        tbl[9]  = '{32'h8182837E, 8'h83, 8'h7E};
        tbl[10] = '{32'hFF80FE81, 8'hFF, 8'hFF};
        tbl[11] = '{32'h55AA33CC, 8'hCC, 8'h55};
        tbl[12] = '{32'h00010002, 8'h02, 8'h02};
        tbl[13] = '{32'hC0D0E0F0, 8'hF0, 8'hF0};
        tbl[14] = '{32'h7E7F7D7C, 8'h7F, 8'h7F};
        tbl[15] = '{32'h12345678, 8'h78, 8'h78};

        for (int k = 0; k < 16; k++)
            in_win[k] = 32'd0;
        accepted = 0;
        lasts = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        do_reset();

        $display("[TB] single frame, latency");
        for (int i = 0; i < 25; i++) begin
            rand_win();
            in_win[0] = 32'h10203040;
            apply_stimulus(1'b1, 1'b1);
        end
        chk("lat_e0_valid", 128'(valid_u), 128'(0));
        apply_stimulus(1'b0, 1'b1);
        chk("lat_e1_valid", 128'(valid_u), 128'(1));
        chk("lat_e1_ch0", 128'(data_u[7:0]), 128'(8'h40));
        drain(30);
        chk("single_count", 128'(accepted), 128'(25));
        chk("single_lasts", 128'(lasts), 128'(1));

        $display("[TB] table vectors");
        for (int i = 0; i < 25; i++) begin
            for (int k = 0; k < 16; k++)
                in_win[k] = tbl[k].win;
            apply_stimulus(1'b1, 1'b0);
        end
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("tbl%0d_u", k), 128'(data_u[8*k +: 8]), 128'(tbl[k].exp_u));
            chk($sformatf("tbl%0d_s", k), 128'(data_s[8*k +: 8]), 128'(tbl[k].exp_s));
        end
        drain(30);

        $display("[TB] backpressure");
        accepted = 0;
        for (int i = 0; i < 25; i++) begin
            rand_win();
            in_win[0] = {4{8'(i)}};
            apply_stimulus(1'b1, (i % 4 == 0) || (i % 4 == 3));
        end
        for (int i = 25; i < 145; i++)
            apply_stimulus(1'b0, (i % 4 == 0) || (i % 4 == 3));
        chk("bp_count", 128'(accepted), 128'(25));

        $display("[TB] back-to-back frames");
        accepted = 0;
        lasts = 0;
        send_frames(50, 1'b1);
        drain(40);
        chk("b2b_count", 128'(accepted), 128'(50));
        chk("b2b_lasts", 128'(lasts), 128'(2));
        chk("b2b_ovf", 128'(ovf_u), 128'(0));

        $display("[TB] overflow");
        send_frames(75, 1'b0);
        chk("ovf_set", 128'(ovf_u), 128'(1));
        accepted = 0;
        drain(70);
        chk("ovf_count", 128'(accepted), 128'(50));

        $display("[TB] randomized traffic");
        begin
            int sent;
            bit v;
            sent = 0;
            for (int c = 0; c < 1500 && sent < 100; c++) begin
                v = ($urandom_range(0, 9) < 7);
                rand_win();
                apply_stimulus(v, $urandom_range(0, 9) < 6);
                if (v)
                    sent++;
            end
            chk("rand_sent", 128'(sent), 128'(100));
        end
        drain(80);

        $display("[TB] reset mid-frame");
        send_frames(12, 1'b1);
        do_reset();
        accepted = 0;
        send_frames(25, 1'b1);
        drain(40);
        chk("rst_frame_count", 128'(accepted), 128'(25));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
